// File: rtl/cb_pkg.sv
// cb_pkg: shared constants and derivation helpers for the configurable
// connection block (cb_cfg_mux).
//   - clog2 helper
//   - nsrc_f / selw_f / sideb_f / cfg_bits_f: derive mux source count, select
//     width, per-side config bits and total chain length from the parameters
//   - SRC_SINGLE and src_*_base: index of the first source of each kind in the
//     flattened per-side mux source vector
package cb_pkg;

  // Single tracks always start the source vector.
  localparam int SRC_SINGLE = 0;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int nsrc_f(input int ws, input int wd, input int wg,
                                input int clbx, input int clbout);
    return ws + wd + wg + clbx * clbout;
  endfunction

  // One extra code is reserved for sel=0 (drive 0).
  function automatic int selw_f(input int nsrc);
    return clog2(nsrc + 1);
  endfunction

  function automatic int sideb_f(input int clbin, input int selw, input int clbout,
                                 input int clbos, input int clbod);
    return clbin * selw + clbout * (clbos + clbod);
  endfunction

  function automatic int cfg_bits_f(input int sideb);
    return 2 * sideb;
  endfunction

  function automatic int src_double_base(input int ws);
    return ws;
  endfunction

  function automatic int src_global_base(input int ws, input int wd);
    return ws + wd;
  endfunction

  function automatic int src_clbx_base(input int ws, input int wd, input int wg);
    return ws + wd + wg;
  endfunction

endpackage

// File: rtl/cb_input_mux.sv
// cb_input_mux: encoded NSRC:1 mux feeding one CLB input.
//   src : NSRC source bits (source k-1 is selected by sel=k)
//   sel : SELW-bit encoded select; 0 and values above NSRC drive 0
//   y   : selected bit
module cb_input_mux #(
  parameter int NSRC = 20,
  parameter int SELW = 5
) (
  input  logic [NSRC-1:0] src,
  input  logic [SELW-1:0] sel,
  output logic            y
);

  localparam int DEPTH = 1 << SELW;

  // Zero-padded lookup: slot 0 and every slot past NSRC read as 0, so the
  // select can index directly without a range check.
  logic [DEPTH-1:0] ext_s;

  // Build the padded source table.
  always_comb begin
    ext_s         = '0;
    ext_s[NSRC:1] = src;
  end

  assign y = ext_s[sel];

endmodule

// File: rtl/cb_cfg_mux.sv
// cb_cfg_mux: self-configuring connection block between two CLBs.
// Config is shifted serially into a shadow register and committed atomically
// to the active register; the active register drives encoded CLB input muxes
// and track driver enables. The datapath is purely combinational.
//   clk, rst_n              : clock, async active-low reset
//   cfg_in/cfg_shift/cfg_load : serial data, shift enable, commit pulse
//   cfg_out                 : serial chain output (shadow[0])
//   cfg_valid               : a good commit happened since reset
//   cfg_err                 : one-cycle pulse after a load with wrong bit count
//   single_*/double_*       : unidirectional routing tracks, global: inputs only
//   clbN_output/clbN_cout   : CLB outputs and carry outs
//   clbN_input/clbN_cin     : CLB inputs and carry ins
module cb_cfg_mux
  import cb_pkg::*;
#(
  parameter int WS      = 8,
  parameter int WD      = 8,
  parameter int WG      = 3,
  parameter int CLBIN   = 6,
  parameter int CLBOUT  = 1,
  parameter int CARRY   = 1,
  parameter int CLBOS   = 2,
  parameter int CLBOD   = 2,
  parameter int OS_BIAS = 0,
  parameter int OD_BIAS = 0,
  parameter int CLBX    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_in,
  input  logic              cfg_shift,
  input  logic              cfg_load,
  output logic              cfg_out,
  output logic              cfg_valid,
  output logic              cfg_err,
  input  logic [WS-1:0]     single_in,
  output logic [WS-1:0]     single_out,
  input  logic [WD-1:0]     double_in,
  output logic [WD-1:0]     double_out,
  input  logic [WG-1:0]     global,
  input  logic [CLBOUT-1:0] clb0_output,
  input  logic [CLBOUT-1:0] clb1_output,
  input  logic [CARRY-1:0]  clb0_cout,
  input  logic [CARRY-1:0]  clb1_cout,
  output logic [CLBIN-1:0]  clb0_input,
  output logic [CLBIN-1:0]  clb1_input,
  output logic [CARRY-1:0]  clb0_cin,
  output logic [CARRY-1:0]  clb1_cin
);

  localparam int NSRC       = nsrc_f(WS, WD, WG, CLBX, CLBOUT);
  localparam int SELW       = selw_f(NSRC);
  localparam int SIDEB      = sideb_f(CLBIN, SELW, CLBOUT, CLBOS, CLBOD);
  localparam int CFG_BITS   = cfg_bits_f(SIDEB);
  localparam int EN_BASE    = CLBIN * SELW;
  localparam int TAPS       = CLBOS + CLBOD;
  localparam int SRC_DOUBLE = src_double_base(WS);
  localparam int SRC_GLOBAL = src_global_base(WS, WD);
  localparam int SRC_CLBX   = src_clbx_base(WS, WD, WG);
  // Counter must hold the saturation value CFG_BITS+1.
  localparam int CNT_W      = clog2(CFG_BITS + 2);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] shadow_r;
  logic [CFG_BITS-1:0] active_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                cfg_valid_r;
  logic                cfg_err_r;

  // Config chain: shift into shadow, commit to active on a correctly sized load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r    <= '0;
      active_r    <= '0;
      cnt_r       <= '0;
      cfg_valid_r <= 1'b0;
      cfg_err_r   <= 1'b0;
    end else if (cfg_load) begin
      // Load has priority over a simultaneous shift; shadow is left untouched.
      cnt_r <= '0;
      if (cnt_r == CNT_FULL) begin
        active_r    <= shadow_r;
        cfg_valid_r <= 1'b1;
        cfg_err_r   <= 1'b0;
      end else begin
        cfg_err_r   <= 1'b1;
      end
    end else begin
      cfg_err_r <= 1'b0;
      if (cfg_shift) begin
        shadow_r <= {cfg_in, shadow_r[CFG_BITS-1:1]};
        if (cnt_r != CNT_SAT) begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign cfg_out   = shadow_r[0];
  assign cfg_valid = cfg_valid_r;
  assign cfg_err   = cfg_err_r;

  // Carry chain is a straight crossover between the two CLBs.
  assign clb1_cin = clb0_cout;
  assign clb0_cin = clb1_cout;

  // Per-side mux sources; each side sees the other side's CLB outputs.
  logic [NSRC-1:0] src0_s;
  logic [NSRC-1:0] src1_s;

  assign src0_s[SRC_SINGLE +: WS] = single_in;
  assign src0_s[SRC_DOUBLE +: WD] = double_in;
  assign src0_s[SRC_GLOBAL +: WG] = global;
  assign src1_s[SRC_SINGLE +: WS] = single_in;
  assign src1_s[SRC_DOUBLE +: WD] = double_in;
  assign src1_s[SRC_GLOBAL +: WG] = global;

  if (CLBX != 0) begin : g_clbx
    assign src0_s[SRC_CLBX +: CLBOUT] = clb1_output;
    assign src1_s[SRC_CLBX +: CLBOUT] = clb0_output;
  end

  for (genvar i = 0; i < CLBIN; i++) begin : g_in
    cb_input_mux #(.NSRC(NSRC), .SELW(SELW)) u_mux0 (
      .src (src0_s),
      .sel (active_r[i*SELW +: SELW]),
      .y   (clb0_input[i])
    );
    cb_input_mux #(.NSRC(NSRC), .SELW(SELW)) u_mux1 (
      .src (src1_s),
      .sel (active_r[SIDEB + i*SELW +: SELW]),
      .y   (clb1_input[i])
    );
  end

  logic [1:0][CLBOUT-1:0] drv_s;
  logic [WS-1:0]          single_s;
  logic [WD-1:0]          double_s;

  assign drv_s[0] = clb0_output;
  assign drv_s[1] = clb1_output;

  // Track drivers. Drivers are applied from lowest to highest priority so the
  // last write wins: side 1 before side 0, higher output index before lower.
  always_comb begin
    single_s = single_in;
    double_s = double_in;
    for (int s = 1; s >= 0; s--) begin
      for (int o = CLBOUT - 1; o >= 0; o--) begin
        for (int k = CLBOS - 1; k >= 0; k--) begin
          single_s[(o*CLBOS + k + OS_BIAS) % WS] =
            active_r[s*SIDEB + EN_BASE + o*TAPS + k] ? drv_s[s][o]
                                                      : single_s[(o*CLBOS + k + OS_BIAS) % WS];
        end
        for (int k = CLBOD - 1; k >= 0; k--) begin
          double_s[(o*CLBOD + k + OD_BIAS) % (WD/2)] =
            active_r[s*SIDEB + EN_BASE + o*TAPS + CLBOS + k] ? drv_s[s][o]
                                                              : double_s[(o*CLBOD + k + OD_BIAS) % (WD/2)];
        end
      end
    end
  end

  assign single_out = single_s;
  assign double_out = double_s;

endmodule
